// File: rtl/mandel_pix_writer_if.sv
// Result bus from the Mandelbrot iteration engine to the pixel writer.
// Master drives the pixel result; slave returns res_ready.
interface mandel_pix_writer_if #(
  parameter int ITER_W = 8
);
  logic              res_valid;
  logic              res_ready;
  logic [8:0]        res_px;
  logic [8:0]        res_py;
  logic [ITER_W-1:0] res_iter;
  logic              res_inset;

  modport master (
    output res_valid,
    output res_px,
    output res_py,
    output res_iter,
    output res_inset,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_px,
    input  res_py,
    input  res_iter,
    input  res_inset,
    output res_ready
  );
endinterface

// File: rtl/mandel_pix_writer.sv
// Colour-maps engine results, buffers them and drives the framebuffer
// write port; counts pixels per frame and discarded out-of-range results.
module mandel_pix_writer #(
  parameter int N_PIX_X    = 192,
  parameter int N_PIX_Y    = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int ITER_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  mandel_pix_writer_if.slave  res,
  input  logic                wr_ready,
  output logic [7:0]          wx,
  output logic [6:0]          wy,
  output logic [1:0]          wd,
  output logic                we,
  output logic                frame_done,
  output logic [14:0]         pix_count,
  output logic [7:0]          drop_count
);

  localparam int AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FRAME = N_PIX_X * N_PIX_Y;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] c;
  } pix_t;

  pix_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          in_range;
  logic          accept;
  logic          push;
  logic          drop;
  logic          pop;
  logic [1:0]    colour;
  pix_t          push_ent;
  pix_t          head;
  logic          last_pix;

  // Ready depends only on the registered fill level, never on the pop.
  assign res.res_ready = !rst &&
    (count < (AW+1)'(FIFO_DEPTH));

  assign in_range = (res.res_px < 9'(N_PIX_X)) &&
                    (res.res_py < 9'(N_PIX_Y));
  assign accept   = res.res_valid && res.res_ready;
  assign push     = accept && in_range;
  assign drop     = accept && !in_range;
  assign pop      = (count != '0) && wr_ready;
  assign head     = mem[rd_ptr];
  assign last_pix = pix_count == 15'(FRAME - 1);

  // Diverged pixels never map to black.
  always_comb begin
    colour = 2'd0;
    unique case (1'b1)
      res.res_inset:
        colour = 2'd0;
      (!res.res_inset && res.res_iter[1:0] == 2'd0):
        colour = 2'd3;
      default:
        colour = res.res_iter[1:0];
    endcase
  end

  always_comb begin
    push_ent   = '0;
    push_ent.x = res.res_px[7:0];
    push_ent.y = res.res_py[6:0];
    push_ent.c = colour;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push)
                     - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we         <= 1'b0;
      wx         <= '0;
      wy         <= '0;
      wd         <= '0;
      frame_done <= 1'b0;
      pix_count  <= '0;
    end else begin
      we         <= pop;
      frame_done <= pop && last_pix;
      if (pop) begin
        wx <= head.x;
        wy <= head.y;
        wd <= head.c;
        if (last_pix) begin
          pix_count <= '0;
        end else begin
          pix_count <= pix_count + 15'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && drop_count != 8'hff) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mandel_pix_writer.sv
// Randomised bench for mandel_pix_writer against a queue-based model
// of the pixel stream, plus directed checks of the headline scenarios.
module tb_mandel_pix_writer;

  localparam int NX    = 192;
  localparam int NY    = 128;
  localparam int DEPTH = 4;
  localparam int FRAME = NX * NY;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_ready;
  logic [7:0]  wx;
  logic [6:0]  wy;
  logic [1:0]  wd;
  logic        we;
  logic        frame_done;
  logic [14:0] pix_count;
  logic [7:0]  drop_count;

  mandel_pix_writer_if #(.ITER_W(8)) res_bus ();

  mandel_pix_writer #(
    .N_PIX_X(NX),
    .N_PIX_Y(NY),
    .FIFO_DEPTH(DEPTH),
    .ITER_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .res(res_bus),
    .wr_ready(wr_ready),
    .wx(wx),
    .wy(wy),
    .wd(wd),
    .we(we),
    .frame_done(frame_done),
    .pix_count(pix_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: pending pixels and expected registered outputs.
  int q_x[$];
  int q_y[$];
  int q_c[$];
  int e_we, e_wx, e_wy, e_wd, e_fd, e_pix, e_drop;
  bit armed = 0;
  int we_seen = 0;
  int fd_seen = 0;

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int colour_of(input int it, input bit ins);
    if (ins) return 0;
    if ((it % 4) == 0) return 3;
    return it % 4;
  endfunction

  task automatic step(input bit r, input bit v, input int px,
                      input int py, input int it, input bit ins,
                      input bit wr, output bit acc);
    bit m_rdy;
    @(negedge clk);
    if (armed) begin
      chk("we", int'(we), e_we);
      chk("wx", int'(wx), e_wx);
      chk("wy", int'(wy), e_wy);
      chk("wd", int'(wd), e_wd);
      chk("frame_done", int'(frame_done), e_fd);
      chk("pix_count", int'(pix_count), e_pix);
      chk("drop_count", int'(drop_count), e_drop);
      if (we === 1'b1) we_seen++;
      if (frame_done === 1'b1) fd_seen++;
    end
    rst                = r;
    res_bus.res_valid  = v;
    res_bus.res_px     = 9'(px);
    res_bus.res_py     = 9'(py);
    res_bus.res_iter   = 8'(it);
    res_bus.res_inset  = ins;
    wr_ready           = wr;
    #1;
    m_rdy = !r && (q_x.size() < DEPTH);
    if (armed) chk("res_ready", int'(res_bus.res_ready), int'(m_rdy));
    acc = v && m_rdy;
    if (r) begin
      q_x.delete();
      q_y.delete();
      q_c.delete();
      e_we = 0; e_wx = 0; e_wy = 0; e_wd = 0;
      e_fd = 0; e_pix = 0; e_drop = 0;
      armed = 1;
    end else begin
      if (q_x.size() > 0 && wr) begin
        e_we  = 1;
        e_wx  = q_x.pop_front();
        e_wy  = q_y.pop_front();
        e_wd  = q_c.pop_front();
        e_pix = (e_pix + 1) % FRAME;
        e_fd  = (e_pix == 0) ? 1 : 0;
      end else begin
        e_we = 0;
        e_fd = 0;
      end
      if (acc) begin
        if (px < NX && py < NY) begin
          q_x.push_back(px);
          q_y.push_back(py);
          q_c.push_back(colour_of(it, ins));
        end else if (e_drop < 255) begin
          e_drop++;
        end
      end
    end
  endtask

  task automatic idle(input bit wr);
    bit a;
    step(0, 0, 0, 0, 0, 0, wr, a);
  endtask

  initial begin
    bit a;
    int n;
    int x;
    int y;
    int cyc;
    rst               = 1'b1;
    wr_ready          = 1'b0;
    res_bus.res_valid = 1'b0;
    res_bus.res_px    = '0;
    res_bus.res_py    = '0;
    res_bus.res_iter  = '0;
    res_bus.res_inset = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, a);
    step(1, 0, 0, 0, 0, 0, 0, a);
    idle(0);

    // Reset with pixels still buffered must lose them.
    step(0, 1, 10, 11, 1, 0, 0, a);
    step(0, 1, 12, 13, 2, 0, 0, a);
    step(0, 1, 14, 15, 3, 0, 0, a);
    step(1, 1, 16, 17, 3, 0, 1, a);
    chk("rst_ready_low", int'(res_bus.res_ready), 0);
    we_seen = 0;
    for (int i = 0; i < 6; i++) idle(1);
    chk("rst_no_we", we_seen, 0);
    chk("rst_pix_count", int'(pix_count), 0);
    chk("rst_ready_back", int'(res_bus.res_ready), 1);

    // Single pixel, one-cycle write latency.
    step(0, 1, 5, 7, 6, 0, 1, a);
    idle(1);
    idle(1);
    chk("single_we", int'(we), 1);
    chk("single_wx", int'(wx), 5);
    chk("single_wy", int'(wy), 7);
    chk("single_wd", int'(wd), 2);
    chk("single_pix", int'(pix_count), 1);

    // Colour map.
    step(0, 1, 1, 1, 4, 0, 1, a);
    step(0, 1, 2, 1, 9, 0, 1, a);
    step(0, 1, 3, 1, 99, 1, 1, a);
    chk("colour_iter4", int'(wd), 3);
    idle(1);
    chk("colour_iter9", int'(wd), 1);
    idle(1);
    chk("colour_inset", int'(wd), 0);
    idle(1);

    // Backpressure: only DEPTH results fit.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 20 + i, 30, i + 1, 0, 0, a);
      if (a) n++;
    end
    chk("bp_accepted", n, DEPTH);
    chk("bp_ready_low", int'(res_bus.res_ready), 0);
    we_seen = 0;
    for (int i = 0; i < 6; i++) idle(1);
    chk("bp_we_pulses", we_seen, DEPTH);

    // Out-of-range results are consumed and counted.
    step(0, 1, 192, 0, 1, 0, 1, a);
    step(0, 1, 0, 128, 1, 0, 1, a);
    we_seen = 0;
    idle(1);
    idle(1);
    chk("drop_no_we", we_seen, 0);
    chk("drop_two", int'(drop_count), 2);
    for (int i = 0; i < 300; i++)
      step(0, 1, $urandom_range(192, 511), $urandom_range(0, 511),
           $urandom_range(0, 255), 1'($urandom), 1'($urandom), a);
    idle(1);
    idle(1);
    chk("drop_sat", int'(drop_count), 255);

    // Random mix of traffic, stalls and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      bit rr;
      bit oor;
      rr  = ($urandom_range(0, 99) == 0);
      oor = ($urandom_range(0, 9) == 0);
      step(rr, 1'($urandom), oor ? $urandom_range(192, 511)
                                 : $urandom_range(0, NX - 1),
           $urandom_range(0, NY - 1), $urandom_range(0, 255),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), a);
    end

    // Full frame in raster order with random stalls on both sides.
    step(1, 0, 0, 0, 0, 0, 0, a);
    we_seen = 0;
    fd_seen = 0;
    x = 0;
    y = 0;
    cyc = 0;
    while (y < NY && cyc < 60000) begin
      step(0, ($urandom_range(0, 7) != 0), x, y,
           $urandom_range(0, 255), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0), a);
      if (a) begin
        x++;
        if (x == NX) begin
          x = 0;
          y++;
        end
      end
      cyc++;
    end
    chk("frame_stream_budget", y, NY);
    for (int i = 0; i < 8; i++) idle(1);
    chk("frame_we_pulses", we_seen, FRAME);
    chk("frame_done_pulses", fd_seen, 1);
    chk("frame_pix_wrap", int'(pix_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mandel_pix_writer.md
Name: mandel_pix_writer

Overview:
- Downstream of the Mandelbrot iteration engine; consumes one result per pixel (coordinates, iteration count, in-set flag).
- Maps each result to a 2-bit colour and buffers it in a small FIFO.
- Drives the video framebuffer write port (wx/wy/wd/we) on the engine clock.
- Tracks frame completion.

Parameters:
- N_PIX_X, 192, frame width in pixels; valid px range 0..N_PIX_X-1.
- N_PIX_Y, 128, frame height in pixels; valid py range 0..N_PIX_Y-1.
- FIFO_DEPTH, 4, result buffer entries; power of two, minimum 2.
- ITER_W, 8, iteration count width.

Ports:
- clk  in  1  engine clock (24 MHz); all logic on rising edge.
- rst  in  1  synchronous reset, active high.
- res_valid  in  1  result present.
- res_ready  out  1  block can accept a result.
- res_px  in  9  pixel X.
- res_py  in  9  pixel Y.
- res_iter  in  ITER_W  iterations completed.
- res_inset  in  1  1 = iteration max reached (in set); 0 = diverged.
- wr_ready  in  1  framebuffer can accept a write this cycle.
- wx  out  8  framebuffer write X.
- wy  out  7  framebuffer write Y.
- wd  out  2  framebuffer write data (colour index).
- we  out  1  framebuffer write enable, one cycle per pixel.
- frame_done  out  1  one-cycle pulse on the last pixel of a frame.
- pix_count  out  15  pixels written in the current frame.
- drop_count  out  8  out-of-range results discarded; saturates at 255.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on ports clk and rst.
- Reset (rst=1 at an edge):
  - FIFO emptied; we=0, wx=0, wy=0, wd=0, frame_done=0, pix_count=0, drop_count=0.
  - res_ready=0 while rst=1; inputs ignored.
  - Reset mid-operation discards buffered and in-flight pixels; no we after the reset edge.
- Input handshake:
  - res_ready = !rst && (fifo count < FIFO_DEPTH), derived from registered count only.
  - A transfer occurs on an edge where res_valid && res_ready.
  - Inputs are don't-care when res_valid=0.
- Range check at accept:
  - If res_px >= N_PIX_X or res_py >= N_PIX_Y, the result is consumed but not enqueued.
  - drop_count increments by 1, holding at 255.
- Colour map, computed at enqueue:
  - res_inset=1 -> wd=0 (black).
  - Otherwise wd=res_iter[1:0]; if that value is 0, wd=3. Diverged pixels are never black.
  - Stored entry is {px[7:0], py[6:0], colour}, 17 bits.
- Write stage:
  - Pop occurs on an edge where the FIFO is non-empty and wr_ready=1.
  - After that edge: wx/wy/wd = head entry, we=1 for exactly one cycle.
  - On edges with no pop, we=0 and wx/wy/wd hold their last value.
  - Latency: with FIFO empty and wr_ready=1, a result accepted at edge E appears with we=1 after edge E+1.
  - Throughput: one pixel per cycle when wr_ready is held high.
- Simultaneous push and pop: allowed when not full; count unchanged; FIFO order preserved.
  - When full, no push occurs even if a pop happens on the same edge, because res_ready is registered-count based.
- Frame tracking:
  - pix_count increments on every edge that pops an entry.
  - If the increment would reach N_PIX_X*N_PIX_Y (24576), pix_count wraps to 0 instead.
  - frame_done=1 in the same cycle as that final we; otherwise frame_done=0.
  - Dropped results do not count.
- No combinational path from wr_ready to we/wx/wy/wd; all outputs except res_ready are registered.

Test Plan:
1. Reset mid-stream: fill FIFO with 3 pixels, wr_ready=0, assert rst 1 cycle -> res_ready=0 during rst; no we ever after; pix_count=0; then res_ready=1.
2. Single pixel: px=5, py=7, iter=6, inset=0, wr_ready=1 -> one cycle after accept: we=1, wx=5, wy=7, wd=2; pix_count=1.
3. Colour map: iter=4/inset=0 -> wd=3; iter=9/inset=0 -> wd=1; iter=99/inset=1 -> wd=0.
4. Backpressure: wr_ready=0, offer 6 results back-to-back -> exactly FIFO_DEPTH=4 accepted, res_ready=0. Raise wr_ready -> 4 we pulses on consecutive cycles in input order; res_ready returns to 1 after the first pop.
5. Range drop: px=192, py=0 and px=0, py=128 -> both consumed, no we, drop_count=2. After 300 out-of-range results, drop_count=255.
6. Full frame: stream all 192x128 in-range pixels with random wr_ready -> 24576 we pulses; frame_done pulses exactly once, with the final we; pix_count then 0.
